ex_div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the EX stage, executing MIPS DIV/DIVU. It sits directly upstream of the hazard/forwarding unit and drives its `ex_is_write_hi`/`ex_is_write_lo` and `ex_write_hi_value`/`ex_write_lo_value` inputs. While a division is in flight it asserts a stall request that the pipeline control ORs into the PC/IF-ID hold and ID/EX bubble logic.

---
 rtl/ex_div_unit_pkg.sv | 16 +
 rtl/ex_div_unit_if.sv | 27 ++
 rtl/ex_div_unit_iter_step.sv | 29 ++
 rtl/ex_div_unit.sv | 141 ++++++++++++++
 tb/tb_ex_div_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider: widths, FSM encoding,
// and the divide-by-zero quotient.
package div_pkg;

    localparam int unsigned DIV_W    = 32;
    localparam int unsigned DIV_ITER = 32;

    localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_if.sv
// EX-stage divider request/response bundle between pipeline control (master)
// and the divider (slave).
interface ex_div_unit_if #(
    parameter int unsigned W = 32
);

    logic         ex_div_start;
    logic         ex_div_signed;
    logic [W-1:0] ex_div_dividend;
    logic [W-1:0] ex_div_divisor;
    logic         ex_div_flush;
    logic         ex_div_stall;
    logic         ex_div_done;
    logic [W-1:0] ex_div_quotient;
    logic [W-1:0] ex_div_remainder;

    modport master (
        output ex_div_start, ex_div_signed, ex_div_dividend, ex_div_divisor, ex_div_flush,
        input  ex_div_stall, ex_div_done, ex_div_quotient, ex_div_remainder
    );

    modport slave (
        input  ex_div_start, ex_div_signed, ex_div_dividend, ex_div_divisor, ex_div_flush,
        output ex_div_stall, ex_div_done, ex_div_quotient, ex_div_remainder
    );

endinterface

// File: rtl/ex_div_unit_iter_step.sv
// One combinational restoring-division step on magnitudes.
module div_iter_step
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic [W:0]   prem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] dvs,
    output logic [W:0]   prem_nx,
    output logic [W-1:0] quo_nx
);

    localparam int unsigned SW = W + 2;
    localparam int unsigned RW = W + 1;

    logic [SW-1:0] shifted;
    logic [SW-1:0] diff;
    logic          neg;

    // Extra top bit keeps the trial subtraction's sign separate from the remainder.
    assign shifted = {prem, quo[W-1]};
    assign diff    = shifted - SW'(dvs);
    assign neg     = diff[SW-1];

    assign prem_nx = neg ? RW'(shifted) : RW'(diff);
    assign quo_nx  = {quo[W-2:0], ~neg};

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: restoring divider with sign
// correction, pipeline stall request and one-cycle done pulse.
module ex_div_unit
#(
    parameter int unsigned DIV_W    = div_pkg::DIV_W,
    parameter int unsigned DIV_ITER = div_pkg::DIV_ITER
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_unit_if.slave  bus
);

    import div_pkg::*;

    localparam int unsigned CNT_W = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    div_state_e       state;
    div_state_e       state_nx;
    logic [CNT_W-1:0] cnt;

    // Working registers, kept apart from the output registers.
    logic [DIV_W:0]   prem;
    logic [DIV_W-1:0] quo;
    logic [DIV_W-1:0] dvs;
    logic             q_neg;
    logic             r_neg;

    logic [DIV_W:0]   prem_nx;
    logic [DIV_W-1:0] quo_nx;

    logic             accept_c;
    logic             zero_div_c;
    logic             finish_c;
    logic             stall_c;

    logic             done;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;

    logic             a_neg;
    logic             b_neg;
    logic [DIV_W-1:0] a_mag;
    logic [DIV_W-1:0] b_mag;

    assign a_neg = bus.ex_div_signed & bus.ex_div_dividend[DIV_W-1];
    assign b_neg = bus.ex_div_signed & bus.ex_div_divisor[DIV_W-1];
    assign a_mag = a_neg ? DIV_W'(0) - bus.ex_div_dividend : bus.ex_div_dividend;
    assign b_mag = b_neg ? DIV_W'(0) - bus.ex_div_divisor  : bus.ex_div_divisor;

    div_iter_step #(.W(DIV_W)) u_step (
        .prem    (prem),
        .quo     (quo),
        .dvs     (dvs),
        .prem_nx (prem_nx),
        .quo_nx  (quo_nx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush overrides every state
    always_comb begin
        state_nx = state;
        if (bus.ex_div_flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.ex_div_start)
                             state_nx = (bus.ex_div_divisor == DIV_W'(0)) ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == CNT_LAST) state_nx = ST_DONE;
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        accept_c   = 1'b0;
        zero_div_c = 1'b0;
        finish_c   = 1'b0;
        stall_c    = 1'b0;
        if (!bus.ex_div_flush) begin
            accept_c   = (state == ST_IDLE) && bus.ex_div_start;
            zero_div_c = accept_c && (bus.ex_div_divisor == DIV_W'(0));
            finish_c   = (state == ST_CALC) && (cnt == CNT_LAST);
            stall_c    = accept_c || (state == ST_CALC);
        end
    end

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            prem  <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept_c) begin
            cnt   <= '0;
            prem  <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
        end else if (state == ST_CALC) begin
            cnt  <= cnt + CNT_W'(1);
            prem <= prem_nx;
            quo  <= quo_nx;
        end
    end

    // Result registers hold until the next completed operation
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= finish_c | zero_div_c;
            if (zero_div_c) begin
                quotient  <= DIV_W'(DZ_QUOTIENT);
                remainder <= bus.ex_div_dividend;
            end else if (finish_c) begin
                quotient  <= q_neg ? DIV_W'(0) - quo_nx : quo_nx;
                remainder <= r_neg ? DIV_W'(0) - prem_nx[DIV_W-1:0] : prem_nx[DIV_W-1:0];
            end
        end
    end

    assign bus.ex_div_stall     = stall_c;
    assign bus.ex_div_done      = done;
    assign bus.ex_div_quotient  = quotient;
    assign bus.ex_div_remainder = remainder;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table, flush/reset
// sequences and random operations against an arithmetic reference model.
module tb_ex_div_unit;

    logic clk;
    logic rst;

    ex_div_unit_if bus ();

    ex_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values avoids the INT_MIN/-1 trap.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Starts at a negedge; cycle 0 is the acceptance cycle.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] qe, input logic [31:0] re, input string nm);
        int exp_cyc;
        int cyc;
        int stall_bad;
        bit seen;
        exp_cyc = (b == 32'd0) ? 1 : 33;
        bus.ex_div_start    = 1'b1;
        bus.ex_div_signed   = sgn;
        bus.ex_div_dividend = a;
        bus.ex_div_divisor  = b;
        bus.ex_div_flush    = 1'b0;
        #1;
        stall_bad = (bus.ex_div_stall !== 1'b1) ? 1 : 0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.ex_div_done === 1'b1) seen = 1'b1;
            else if (bus.ex_div_stall !== 1'b1) stall_bad++;
        end
        check({nm, " done_cycle"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
        if (seen) begin
            if (bus.ex_div_stall !== 1'b0) stall_bad++;
            check({nm, " quotient"}, bus.ex_div_quotient, qe);
            check({nm, " remainder"}, bus.ex_div_remainder, re);
        end
        check({nm, " stall_profile"}, 32'(stall_bad), 32'd0);
        bus.ex_div_start = 1'b0;
        @(negedge clk);
        #1;
        check({nm, " done_drop"}, 32'(bus.ex_div_done), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] qe;
        logic [31:0] re;
        logic [31:0] prev_q;
        logic [31:0] prev_r;
        int pulses;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[4] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[8] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
        vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};

        rst = 1'b1;
        bus.ex_div_start    = 1'b0;
        bus.ex_div_signed   = 1'b0;
        bus.ex_div_dividend = '0;
        bus.ex_div_divisor  = '0;
        bus.ex_div_flush    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset done", 32'(bus.ex_div_done), 32'd0);
        check("reset quotient", bus.ex_div_quotient, 32'd0);
        check("reset remainder", bus.ex_div_remainder, 32'd0);
        check("reset stall", 32'(bus.ex_div_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    $sformatf("vec%0d", i));

        // Flush in cycle 10, then a fresh 9/3 accepted in cycle 11.
        prev_q = vecs[9].q;
        prev_r = vecs[9].r;
        bus.ex_div_start    = 1'b1;
        bus.ex_div_signed   = 1'b0;
        bus.ex_div_dividend = 32'd100;
        bus.ex_div_divisor  = 32'd7;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (bus.ex_div_done === 1'b1) pulses++;
        end
        bus.ex_div_flush = 1'b1;
        #1;
        check("flush stall", 32'(bus.ex_div_stall), 32'd0);
        @(negedge clk);
        bus.ex_div_flush = 1'b0;
        #1;
        if (bus.ex_div_done === 1'b1) pulses++;
        check("flush no_done", 32'(pulses), 32'd0);
        check("flush quotient_hold", bus.ex_div_quotient, prev_q);
        check("flush remainder_hold", bus.ex_div_remainder, prev_r);
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "after_flush");

        // Synchronous reset in cycle 15 of an operation.
        bus.ex_div_start    = 1'b1;
        bus.ex_div_signed   = 1'b1;
        bus.ex_div_dividend = 32'd1000;
        bus.ex_div_divisor  = 32'd3;
        pulses = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            #1;
            if (bus.ex_div_done === 1'b1) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ex_div_start = 1'b0;
        #1;
        check("rst quotient", bus.ex_div_quotient, 32'd0);
        check("rst remainder", bus.ex_div_remainder, 32'd0);
        check("rst stall", 32'(bus.ex_div_stall), 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus.ex_div_done === 1'b1) pulses++;
            @(negedge clk);
            #1;
        end
        check("rst no_done", 32'(pulses), 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic        sgn;
            logic [31:0] a;
            logic [31:0] b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0;
                3:       b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(sgn, a, b, qe, re);
            run_div(sgn, a, b, qe, re, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
